// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Buffers execution-unit results and grants them round-robin onto
//            the register-file write lanes and the shared NZCV write port.
// Revision : 1.0
// ============================================================================
module wb_arbiter #(
  parameter int WORD_SIZE     = 64,
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_SRC       = 4,
  parameter int NUM_WB_LANES  = 2,
  parameter int FIFO_DEPTH    = 2,
  localparam int IDX_W        = $clog2(NUM_PHYS_REGS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_SRC-1:0]                  src_valid,
  output logic [NUM_SRC-1:0]                  src_ready,
  input  logic [NUM_SRC-1:0][IDX_W-1:0]       src_index,
  input  logic [NUM_SRC-1:0][WORD_SIZE-1:0]   src_data,
  input  logic [NUM_SRC-1:0]                  src_nzcv_valid,
  input  logic [NUM_SRC-1:0][IDX_W-1:0]       src_nzcv_index,
  input  logic [NUM_SRC-1:0][3:0]             src_nzcv,
  output logic [NUM_WB_LANES-1:0]             wb_en,
  output logic [NUM_WB_LANES-1:0][IDX_W-1:0]  wb_index,
  output logic [NUM_WB_LANES-1:0][WORD_SIZE-1:0] wb_data,
  output logic                                nzcv_wb_valid,
  output logic [IDX_W-1:0]                    nzcv_wb_index,
  output logic [3:0]                          nzcv_wb_data,
  output logic [31:0]                         conflict_cnt
);

  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic                 r_run;
  logic [c_SRC_W-1:0]   r_rr_ptr;

  logic                 w_head_vld   [NUM_SRC];
  logic [IDX_W-1:0]     w_head_idx   [NUM_SRC];
  logic [WORD_SIZE-1:0] w_head_data  [NUM_SRC];
  logic                 w_head_nzv   [NUM_SRC];
  logic [IDX_W-1:0]     w_head_nzidx [NUM_SRC];
  logic [3:0]           w_head_nzcv  [NUM_SRC];

  logic [NUM_SRC-1:0]   w_grant;
  logic                 w_skip;
  logic                 w_hit;
  logic                 w_nz_used;
  int                   w_lane_cnt;
  int                   w_last;

  // Per-source result buffers; ready depends only on registered occupancy.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    logic [IDX_W-1:0]     r_mem_idx   [FIFO_DEPTH];
    logic [WORD_SIZE-1:0] r_mem_data  [FIFO_DEPTH];
    logic                 r_mem_nzv   [FIFO_DEPTH];
    logic [IDX_W-1:0]     r_mem_nzidx [FIFO_DEPTH];
    logic [3:0]           r_mem_nzcv  [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr;
    logic [c_PTR_W-1:0]   r_rd;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;

    assign w_full       = (r_cnt == c_CNT_W'(FIFO_DEPTH));
    assign src_ready[g] = r_run & ~w_full;
    assign w_push       = src_valid[g] & src_ready[g];
    assign w_pop        = w_grant[g];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_wr  <= '0;
        r_rd  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + c_PTR_W'(1);
        if (w_pop)  r_rd <= r_rd + c_PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
          2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (w_push) begin
        r_mem_idx[r_wr]   <= src_index[g];
        r_mem_data[r_wr]  <= src_data[g];
        r_mem_nzv[r_wr]   <= src_nzcv_valid[g];
        r_mem_nzidx[r_wr] <= src_nzcv_index[g];
        r_mem_nzcv[r_wr]  <= src_nzcv[g];
      end
    end

    assign w_head_vld[g]   = (r_cnt != '0);
    assign w_head_idx[g]   = r_mem_idx[r_rd];
    assign w_head_data[g]  = r_mem_data[r_rd];
    assign w_head_nzv[g]   = r_mem_nzv[r_rd];
    assign w_head_nzidx[g] = r_mem_nzidx[r_rd];
    assign w_head_nzcv[g]  = r_mem_nzcv[r_rd];
  end

  // Round-robin scan from r_rr_ptr; colliding heads are skipped, not stalled.
  always_comb begin
    w_grant       = '0;
    w_skip        = 1'b0;
    w_hit         = 1'b0;
    w_nz_used     = 1'b0;
    w_lane_cnt    = 0;
    w_last        = int'(r_rr_ptr);
    wb_en         = '0;
    wb_index      = '0;
    wb_data       = '0;
    nzcv_wb_valid = 1'b0;
    nzcv_wb_index = '0;
    nzcv_wb_data  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if ((s == (int'(r_rr_ptr) + k) % NUM_SRC) && w_head_vld[s]) begin
          w_hit = 1'b0;
          for (int l = 0; l < NUM_WB_LANES; l++) begin
            if ((l < w_lane_cnt) && (wb_index[l] == w_head_idx[s])) w_hit = 1'b1;
          end
          if (w_head_nzv[s] && w_nz_used) w_hit = 1'b1;
          if (w_hit || (w_lane_cnt >= NUM_WB_LANES)) begin
            w_skip = 1'b1;
          end else begin
            w_grant[s] = 1'b1;
            for (int l = 0; l < NUM_WB_LANES; l++) begin
              if (l == w_lane_cnt) begin
                wb_en[l]    = 1'b1;
                wb_index[l] = w_head_idx[s];
                wb_data[l]  = w_head_data[s];
              end
            end
            if (w_head_nzv[s]) begin
              w_nz_used     = 1'b1;
              nzcv_wb_valid = 1'b1;
              nzcv_wb_index = w_head_nzidx[s];
              nzcv_wb_data  = w_head_nzcv[s];
            end
            w_lane_cnt = w_lane_cnt + 1;
            w_last     = s;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run        <= 1'b0;
      r_rr_ptr     <= '0;
      conflict_cnt <= '0;
    end else begin
      r_run <= 1'b1;
      if (|w_grant) r_rr_ptr <= c_SRC_W'((w_last + 1) % NUM_SRC);
      if (w_skip && (conflict_cnt != 32'hFFFF_FFFF)) conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Directed scoreboard bench for wb_arbiter.
// Revision : 1.0
// ============================================================================
module tb_wb_arbiter;
  localparam int W  = 64;
  localparam int NR = 64;
  localparam int NS = 4;
  localparam int NL = 2;
  localparam int IW = 6;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NS-1:0]        src_valid;
  logic [NS-1:0]        src_ready;
  logic [NS-1:0][IW-1:0] src_index;
  logic [NS-1:0][W-1:0] src_data;
  logic [NS-1:0]        src_nzcv_valid;
  logic [NS-1:0][IW-1:0] src_nzcv_index;
  logic [NS-1:0][3:0]   src_nzcv;
  logic [NL-1:0]        wb_en;
  logic [NL-1:0][IW-1:0] wb_index;
  logic [NL-1:0][W-1:0] wb_data;
  logic                 nzcv_wb_valid;
  logic [IW-1:0]        nzcv_wb_index;
  logic [3:0]           nzcv_wb_data;
  logic [31:0]          conflict_cnt;

  always #5 clk = ~clk;

  wb_arbiter #(
    .WORD_SIZE(W), .NUM_PHYS_REGS(NR), .NUM_SRC(NS), .NUM_WB_LANES(NL), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready), .src_index(src_index), .src_data(src_data),
    .src_nzcv_valid(src_nzcv_valid), .src_nzcv_index(src_nzcv_index), .src_nzcv(src_nzcv),
    .wb_en(wb_en), .wb_index(wb_index), .wb_data(wb_data),
    .nzcv_wb_valid(nzcv_wb_valid), .nzcv_wb_index(nzcv_wb_index), .nzcv_wb_data(nzcv_wb_data),
    .conflict_cnt(conflict_cnt)
  );

  typedef struct { int cyc; logic [IW-1:0] idx; logic [W-1:0] data; } wr_t;
  typedef struct { int cyc; logic [IW-1:0] idx; logic [3:0] f; } nz_t;
  wr_t exp_q[$];
  nz_t nz_q[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected writes whenever the DUT presents a lane or flag write.
  always @(negedge clk) begin
    wr_t e;
    nz_t n;
    if (rst) begin
      chk("lane_packing", {63'd0, wb_en == 2'b10}, 64'd0);
      for (int l = 0; l < NL; l++) begin
        if (wb_en[l]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: lane %0d idx %0d data %0h, nothing expected", l, wb_index[l], wb_data[l]);
          end else begin
            e = exp_q.pop_front();
            chk("wr_cycle", 64'(cyc), 64'(e.cyc));
            chk("wr_index", 64'(wb_index[l]), 64'(e.idx));
            chk("wr_data", wb_data[l], e.data);
          end
        end else begin
          chk("idle_lane_index", 64'(wb_index[l]), 64'd0);
          chk("idle_lane_data", wb_data[l], 64'd0);
        end
      end
      if (wb_en == 2'b11) chk("dup_index", {63'd0, wb_index[0] == wb_index[1]}, 64'd0);
      if (nzcv_wb_valid) begin
        if (nz_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_nzcv: idx %0d flags %b, nothing expected", nzcv_wb_index, nzcv_wb_data);
        end else begin
          n = nz_q.pop_front();
          chk("nz_cycle", 64'(cyc), 64'(n.cyc));
          chk("nz_index", 64'(nzcv_wb_index), 64'(n.idx));
          chk("nz_flags", 64'(nzcv_wb_data), 64'(n.f));
        end
      end else begin
        chk("idle_nzcv", 64'({nzcv_wb_index, nzcv_wb_data}), 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    src_valid      = '0;
    src_index      = '0;
    src_data       = '0;
    src_nzcv_valid = '0;
    src_nzcv_index = '0;
    src_nzcv       = '0;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic drive(input int s, input int idx, input logic [W-1:0] d);
    src_valid[s] = 1'b1;
    src_index[s] = idx[IW-1:0];
    src_data[s]  = d;
  endtask

  task automatic drive_nz(input int s, input int nidx, input logic [3:0] f);
    src_nzcv_valid[s] = 1'b1;
    src_nzcv_index[s] = nidx[IW-1:0];
    src_nzcv[s]       = f;
  endtask

  task automatic exp_wr(input int c, input int idx, input logic [W-1:0] d);
    wr_t e;
    e.cyc  = c;
    e.idx  = idx[IW-1:0];
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic exp_nz(input int c, input int idx, input logic [3:0] f);
    nz_t n;
    n.cyc = c;
    n.idx = idx[IW-1:0];
    n.f   = f;
    nz_q.push_back(n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int fi;
    int li;
    int k;
    logic rf;
    logic rl;

    // Reset held with all sources offering
    clr();
    src_valid = 4'hF;
    rst = 1'b0;
    repeat (3) begin
      step();
      chk("rst_ready", 64'(src_ready), 64'd0);
      chk("rst_wb_en", 64'(wb_en), 64'd0);
      chk("rst_nzcv_valid", 64'(nzcv_wb_valid), 64'd0);
    end
    chk("rst_conflict_cnt", 64'(conflict_cnt), 64'd0);
    chk("rst_rr_ptr", 64'(dut.r_rr_ptr), 64'd0);
    src_valid = '0;
    rst = 1'b1;
    #1;
    chk("ready_before_edge", 64'(src_ready), 64'd0);
    step();
    chk("ready_after_release", 64'(src_ready), 64'hF);
    chk("nothing_buffered", 64'(wb_en), 64'd0);

    // Single ALU result
    drive(0, 5, 64'hDEAD);
    step();
    base = cyc;
    exp_wr(base, 5, 64'hDEAD);
    clr();
    step();
    chk("single_idle_after", 64'(wb_en), 64'd0);
    chk("single_rr_ptr", 64'(dut.r_rr_ptr), 64'd1);

    // All four sources at once from rr_ptr=0
    do_reset();
    for (int s = 0; s < NS; s++) drive(s, s + 1, 64'h100 + 64'(s));
    step();
    base = cyc;
    exp_wr(base, 1, 64'h100);
    exp_wr(base, 2, 64'h101);
    exp_wr(base + 1, 3, 64'h102);
    exp_wr(base + 1, 4, 64'h103);
    clr();
    step();
    step();
    chk("four_conflict_cnt", 64'(conflict_cnt), 64'd1);
    chk("four_rr_ptr", 64'(dut.r_rr_ptr), 64'd0);

    // Same destination index from ALU and LSU
    drive(0, 7, 64'hA1);
    drive(3, 7, 64'hA4);
    step();
    base = cyc;
    exp_wr(base, 7, 64'hA1);
    exp_wr(base + 1, 7, 64'hA4);
    clr();
    step();
    step();
    chk("idx_conflict_cnt", 64'(conflict_cnt), 64'd2);
    chk("idx_rr_ptr", 64'(dut.r_rr_ptr), 64'd0);

    // Two flag writers compete for the single NZCV port
    drive(0, 11, 64'hB0);
    drive_nz(0, 9, 4'b1000);
    drive(2, 12, 64'hB2);
    drive_nz(2, 10, 4'b0100);
    step();
    base = cyc;
    exp_wr(base, 11, 64'hB0);
    exp_nz(base, 9, 4'b1000);
    exp_wr(base + 1, 12, 64'hB2);
    exp_nz(base + 1, 10, 4'b0100);
    clr();
    step();
    step();
    chk("nz_conflict_cnt", 64'(conflict_cnt), 64'd3);
    chk("nz_rr_ptr", 64'(dut.r_rr_ptr), 64'd3);

    // FPU and LSU stream to one index, forcing alternation and backpressure
    do_reset();
    fi = 0;
    li = 0;
    k = 0;
    while ((fi < 3 || li < 3) && k < 10) begin
      clr();
      if (fi < 3) drive(1, 20, 64'(fi + 1));
      if (li < 3) drive(3, 20, 64'h31 + 64'(li));
      rf = src_ready[1];
      rl = src_ready[3];
      step();
      k++;
      if (k == 1) begin
        base = cyc;
        exp_wr(base, 20, 64'h1);
        exp_wr(base + 1, 20, 64'h31);
        exp_wr(base + 2, 20, 64'h2);
        exp_wr(base + 3, 20, 64'h32);
        exp_wr(base + 4, 20, 64'h3);
        exp_wr(base + 5, 20, 64'h33);
      end
      if (k == 3) chk("fpu_backpressure", 64'(src_ready[1]), 64'd0);
      if (fi < 3 && rf) fi++;
      if (li < 3 && rl) li++;
    end
    chk("stream_push_cycles", 64'(k), 64'd4);
    clr();
    repeat (3) step();
    chk("stream_conflict_cnt", 64'(conflict_cnt), 64'd5);

    // Asynchronous reset with entries buffered
    for (int s = 0; s < NS; s++) drive(s, 40 + s, 64'hC0 + 64'(s));
    step();
    clr();
    #1;
    rst = 1'b0;
    #1;
    chk("async_ready", 64'(src_ready), 64'd0);
    chk("async_wb_en", 64'(wb_en), 64'd0);
    chk("async_wb_index", 64'(wb_index), 64'd0);
    chk("async_wb_data0", wb_data[0], 64'd0);
    chk("async_nzcv", 64'({nzcv_wb_valid, nzcv_wb_index, nzcv_wb_data}), 64'd0);
    chk("async_conflict_cnt", 64'(conflict_cnt), 64'd0);
    step();
    rst = 1'b1;
    step();
    step();
    chk("post_reset_empty", 64'(wb_en), 64'd0);
    chk("post_reset_ready", 64'(src_ready), 64'hF);

    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("nz_queue_drained", 64'(nz_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
